uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, start-bit glitch rejection, centre sampling,
// optional parity check, framing error with break hold-off.
module uart_rx #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter string       PARITY     = "NONE",
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  RXD,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_parity_err,
    output logic                  rx_frame_err
);

    localparam int unsigned P          = CLK_FREQ / BAUD_RATE;
    localparam int unsigned FREQ_COUNT = P - 1;
    localparam int unsigned HALF       = FREQ_COUNT / 2;
    localparam int unsigned CNT_W      = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned BIT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam bit          PAR_ODD    = (PARITY == "ODD");
    localparam bit          PAR_EN     = (PARITY == "ODD") || (PARITY == "EVEN");

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PARI  = 3'd3,
        STOP  = 3'd4,
        BREAK = 3'd5
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  sync1;
    logic                  rxs;
    logic                  rxs_d;
    logic [1:0]            fill;
    logic                  armed;
    logic [CNT_W-1:0]      cnt;
    logic [BIT_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_err;
    logic                  tick_half;
    logic                  tick_full;
    logic                  cnt_clr;
    logic                  take_data;
    logic                  take_par;
    logic                  take_stop;

    // Synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (srst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
            fill  <= 2'd0;
        end else begin
            sync1 <= RXD;
            rxs   <= sync1;
            rxs_d <= rxs;
            if (fill != 2'd3) fill <= fill + 2'd1;
        end
    end

    // Edges are only trusted once the reset-forced ones have flushed out of the chain,
    // so a line already low at reset release cannot look like a start bit.
    assign armed = (fill == 2'd3);

    always_ff @(posedge clk) begin
        if (srst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        take_data  = 1'b0;
        take_par   = 1'b0;
        take_stop  = 1'b0;
        tick_half  = (cnt == CNT_W'(HALF));
        tick_full  = (cnt == CNT_W'(FREQ_COUNT));
        case (state)
            IDLE: begin
                if (armed && rxs_d && !rxs) state_next = START;
            end
            START: begin
                if (tick_half) begin
                    if (rxs) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                        cnt_clr    = 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick_full) begin
                    take_data = 1'b1;
                    if (bit_idx == BIT_W'(DATA_WIDTH - 1)) state_next = PAR_EN ? PARI : STOP;
                end
            end
            PARI: begin
                if (tick_full) begin
                    take_par   = 1'b1;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (tick_full) begin
                    take_stop  = 1'b1;
                    state_next = rxs ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rxs) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bit-period counter: parked at zero in IDLE/BREAK, realigned after the start-bit centre.
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt <= '0;
        end else if (state == IDLE || state == BREAK || cnt_clr) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(FREQ_COUNT)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            bit_idx <= '0;
            shreg   <= '0;
            par_err <= 1'b0;
        end else begin
            if (cnt_clr) begin
                bit_idx <= '0;
                par_err <= 1'b0;
            end else if (take_data) begin
                bit_idx <= (bit_idx == BIT_W'(DATA_WIDTH - 1)) ? '0 : bit_idx + BIT_W'(1);
            end
            if (take_data) shreg <= DATA_WIDTH'({rxs, shreg} >> 1);
            if (take_par)  par_err <= (rxs != (PAR_ODD ? ~^shreg : ^shreg));
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_valid <= take_stop;
            if (take_stop) begin
                rx_data       <= shreg;
                rx_parity_err <= par_err;
                rx_frame_err  <= ~rxs;
            end
        end
    end

endmodule
